// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose: hazard and sequencing control for the in-order pipeline. Watches
// the decoded control bundle in ID and EX and produces the PC / IF/ID / ID/EX
// write-enable and flush controls. It handles three cases:
//   - a load-use stall,
//   - a squash on control transfer (branch taken, JAL, JALR),
//   - a halt drain, after which the core reports halted.
//
// Optional feature: defining HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_cycles performance counters and their ports.
//
// Ports:
//   clk               rising-edge clock
//   reset_n           synchronous reset, active-low
//   id_halt           halt decoded for the instruction in ID
//   id_rs1, id_rs2    source registers of the instruction in ID
//   ex_mem_read       instruction in EX is a load
//   ex_rd             destination register of the instruction in EX
//   ex_ctrl_transfer  00 none, 01 branch, 10 JAL, 11 JALR (EX)
//   ex_branch_taken   branch condition result for the EX instruction
//   pc_write          PC register updates this cycle
//   ifid_write        IF/ID register loads (0: holds)
//   ifid_flush        IF/ID loads a bubble
//   idex_flush        ID/EX loads a bubble
//   halted            core halted; sticky until reset
//   stall_cycles      load-use stall cycle count (HAZARD_PERF_CNT_EN only)
//   flush_cycles      redirect flush cycle count (HAZARD_PERF_CNT_EN only)
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal issue; resolves redirect > load_use > halt > normal
// DRAIN  | halt accepted; bubbles into EX while older instructions retire
// HALTED | core stopped; only reset leaves this state
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_halt,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [1:0]       ex_ctrl_transfer,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
`endif
    output logic             halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic redirect;
    logic load_use;
    logic sel_stall;
    logic sel_flush;

    assign redirect = (ex_ctrl_transfer == 2'b10) ||
                      (ex_ctrl_transfer == 2'b11) ||
                      ((ex_ctrl_transfer == 2'b01) && ex_branch_taken);

    // A load to x0 never produces a value, so it can never cause a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        sel_stall  = 1'b0;
        sel_flush  = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    // The instruction in ID is on the wrong path, so a halt
                    // decoded there is discarded together with it.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    sel_flush  = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    sel_stall  = 1'b1;
                end else if (id_halt) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    state_d    = DRAIN;
                    cnt_d      = DRAIN_INIT;
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // While reset is held, keep the pipeline empty regardless of state.
        if (!reset_n) begin
            state_d    = RUN;
            cnt_d      = 4'd0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
            sel_stall  = 1'b0;
            sel_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (sel_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (sel_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_halt;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read;
    logic [1:0] ex_ctrl_transfer;
    logic       ex_branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_halt          (id_halt),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .ex_ctrl_transfer (ex_ctrl_transfer),
        .ex_branch_taken  (ex_branch_taken),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles     (stall_cycles),
        .flush_cycles     (flush_cycles),
`endif
        .halted           (halted)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycles elapsed since halt acceptance (-1: none).
    int since   = -1;
    int stall_m = 0;
    int flush_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic rst, input logic hlt, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                          input logic [1:0] ct, input logic bt);
        reset_n          = rst;
        id_halt          = hlt;
        id_rs1           = rs1;
        id_rs2           = rs2;
        ex_mem_read      = mr;
        ex_rd            = rd;
        ex_ctrl_transfer = ct;
        ex_branch_taken  = bt;
    endtask

    // Inputs are already applied (just after a negedge). Check, then clock
    // the model at the posedge and return at the following negedge.
    task automatic cycle(input string tag);
        bit         redir, lu;
        logic [4:0] exp;
        #1;
        redir = (ex_ctrl_transfer >= 2) || (ex_ctrl_transfer == 1 && ex_branch_taken);
        lu    = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        // exp = {pc_write, ifid_write, ifid_flush, idex_flush, halted}
        if (!reset_n)            exp = 5'b00110;
        else if (since > DRAIN)  exp = 5'b00011;
        else if (since >= 1)     exp = 5'b00010;
        else if (redir)          exp = 5'b11110;
        else if (lu)             exp = 5'b00010;
        else if (id_halt)        exp = 5'b00010;
        else                     exp = 5'b11000;
        check(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, halted}, {27'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(stall_m));
        check({tag, "_flush_cnt"}, 32'(flush_cycles), 32'(flush_m));
`endif
        @(posedge clk);
        if (!reset_n) begin
            since = -1; stall_m = 0; flush_m = 0;
        end else if (since >= 1) begin
            if (since <= DRAIN) since++;
        end else if (redir) begin
            if (flush_m < CNT_MAX) flush_m++;
        end else if (lu) begin
            if (stall_m < CNT_MAX) stall_m++;
        end else if (id_halt) begin
            since = 1;
        end
        @(negedge clk);
    endtask

    task automatic rand_in(input bit allow_reset);
        set_in(allow_reset ? ($urandom_range(0, 59) != 0) : 1'b1,
               $urandom_range(0, 24) == 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)),
               2'($urandom), 1'($urandom));
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        cycle("reset_0");
        cycle("reset_1");
        set_in(1, 0, 1, 2, 0, 0, 0, 0);
        cycle("normal_after_reset");

        set_in(1, 0, 1, 5, 1, 5, 0, 0);
        cycle("load_use");
        set_in(1, 0, 1, 5, 0, 5, 0, 0);
        cycle("after_load_use");
        set_in(1, 0, 5, 5, 1, 5, 0, 0);
        cycle("load_use_both_rs");
        set_in(1, 0, 0, 3, 1, 0, 0, 0);
        cycle("x0_load");

        set_in(1, 1, 0, 0, 0, 0, 2'b01, 1);
        cycle("redirect_over_halt");
        set_in(1, 0, 0, 0, 0, 0, 2'b10, 0);
        cycle("jal_redirect");
        set_in(1, 0, 0, 0, 0, 0, 2'b11, 0);
        cycle("jalr_redirect");
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("normal_after_redirect");

        set_in(1, 1, 0, 0, 0, 0, 2'b01, 0);
        cycle("halt_accept");
        for (int i = 0; i < 50; i++) begin
            rand_in(1'b0);
            cycle("drain_halted");
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset_from_halted");
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("run_after_halted");

        // Counter exercise: 3 stalls, 2 redirects, then enough stalls to saturate.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 7, 0, 1, 7, 0, 0);
            cycle("perf_stall");
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 2'b10, 0);
            cycle("perf_redirect");
        end
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 0, 9, 1, 9, 0, 0);
            cycle("perf_saturate");
        end

        // Mid-drain reset.
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        cycle("halt_accept2");
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("drain_mid");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset_mid_drain");
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("run_after_drain_reset");

        for (int i = 0; i < 2000; i++) begin
            rand_in(1'b1);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
